// File: rtl/ray_generator_pkg.sv
// Shared fixed-point vector types for the ray pipeline.
// fp is signed Q16.16, and vec3 packs x, y and z, in that order, from MSB to LSB.
package ray_generator_pkg;

    localparam int unsigned FP_W = 32;
    localparam real         FP_SCALE = 65536.0;

    typedef logic signed [FP_W-1:0] fp;

    typedef struct packed {
        fp x;
        fp y;
        fp z;
    } vec3;

    function automatic vec3 make_vec3(input fp x, input fp y, input fp z);
        vec3 r;
        r.x = x;
        r.y = y;
        r.z = z;
        return r;
    endfunction

    // Elaboration/testbench helper; truncates toward zero.
    function automatic fp fp_from_real(input real r);
        return fp'($rtoi(r * FP_SCALE));
    endfunction

    // Component-wise two's-complement add that wraps on overflow.
    function automatic vec3 vec3_add(input vec3 a, input vec3 b);
        vec3 r;
        r.x = FP_W'(a.x + b.x);
        r.y = FP_W'(a.y + b.y);
        r.z = FP_W'(a.z + b.z);
        return r;
    endfunction

endpackage

// File: rtl/ray_generator.sv
// Raster-order ray dispatcher: latches a camera on start and issues one ray per pixel
// over a valid/ready handshake, forming each direction incrementally from step vectors.
module ray_generator
    import ray_generator_pkg::*;
#(
    parameter int unsigned DISPLAY_WIDTH  = 400,
    parameter int unsigned DISPLAY_HEIGHT = 300,
    parameter int unsigned H_BITS         = 9,
    parameter int unsigned V_BITS         = 9
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    input  vec3               cam_origin_in,
    input  vec3               cam_dir00_in,
    input  vec3               cam_right_in,
    input  vec3               cam_down_in,
    input  logic [2:0]        fractal_sel_in,
    input  logic              ready_in,
    output logic              valid_out,
    output vec3               ray_origin_out,
    output vec3               ray_direction_out,
    output logic [2:0]        fractal_sel_out,
    output logic [H_BITS-1:0] hcount_out,
    output logic [V_BITS-1:0] vcount_out,
    output logic              busy_out,
    output logic              frame_done_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DONE
    } state_e;

    localparam logic [H_BITS-1:0] H_LAST = H_BITS'(DISPLAY_WIDTH - 1);
    localparam logic [V_BITS-1:0] V_LAST = V_BITS'(DISPLAY_HEIGHT - 1);

    state_e            state_q, state_d;
    logic [H_BITS-1:0] h_q, h_d;
    logic [V_BITS-1:0] v_q, v_d;
    vec3               dir_q, dir_d;
    vec3               row_dir_q, row_dir_d;
    vec3               origin_q, origin_d;
    vec3               right_q, right_d;
    vec3               down_q, down_d;
    logic [2:0]        sel_q, sel_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              xfer_c;

    assign xfer_c = valid_q & ready_in;

    // Next-state, raster stepping and camera latch.
    always_comb begin
        state_d   = state_q;
        h_d       = h_q;
        v_d       = v_q;
        dir_d     = dir_q;
        row_dir_d = row_dir_q;
        origin_d  = origin_q;
        right_d   = right_q;
        down_d    = down_q;
        sel_d     = sel_q;

        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    origin_d  = cam_origin_in;
                    right_d   = cam_right_in;
                    down_d    = cam_down_in;
                    sel_d     = fractal_sel_in;
                    h_d       = '0;
                    v_d       = '0;
                    row_dir_d = cam_dir00_in;
                    dir_d     = cam_dir00_in;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (xfer_c) begin
                    if (h_q != H_LAST) begin
                        h_d   = h_q + H_BITS'(1);
                        dir_d = vec3_add(dir_q, right_q);
                    end else if (v_q != V_LAST) begin
                        h_d       = '0;
                        v_d       = v_q + V_BITS'(1);
                        row_dir_d = vec3_add(row_dir_q, down_q);
                        dir_d     = row_dir_d;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status flags are registered copies of the next state decode.
        valid_d = (state_d == S_ISSUE);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= S_IDLE;
            h_q       <= '0;
            v_q       <= '0;
            dir_q     <= '0;
            row_dir_q <= '0;
            origin_q  <= '0;
            right_q   <= '0;
            down_q    <= '0;
            sel_q     <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            h_q       <= h_d;
            v_q       <= v_d;
            dir_q     <= dir_d;
            row_dir_q <= row_dir_d;
            origin_q  <= origin_d;
            right_q   <= right_d;
            down_q    <= down_d;
            sel_q     <= sel_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign valid_out         = valid_q;
    assign ray_origin_out    = origin_q;
    assign ray_direction_out = dir_q;
    assign fractal_sel_out   = sel_q;
    assign hcount_out        = h_q;
    assign vcount_out        = v_q;
    assign busy_out          = busy_q;
    assign frame_done_out    = done_q;

endmodule

// File: tb/tb_ray_generator.sv
// Scoreboard bench for ray_generator on a 4x3 display: stimulus queues expected rays,
// a negedge monitor pops and compares each accepted ray.
module tb_ray_generator;
    import ray_generator_pkg::*;

    localparam int unsigned W  = 4;
    localparam int unsigned H  = 3;
    localparam int unsigned HB = 9;
    localparam int unsigned VB = 9;

    typedef struct {
        int         h;
        int         v;
        vec3        dir;
        vec3        origin;
        logic [2:0] sel;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          start_in;
    vec3           cam_origin_in;
    vec3           cam_dir00_in;
    vec3           cam_right_in;
    vec3           cam_down_in;
    logic [2:0]    fractal_sel_in;
    logic          ready_in;
    logic          valid_out;
    vec3           ray_origin_out;
    vec3           ray_direction_out;
    logic [2:0]    fractal_sel_out;
    logic [HB-1:0] hcount_out;
    logic [VB-1:0] vcount_out;
    logic          busy_out;
    logic          frame_done_out;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_seen = 0;

    ray_generator #(
        .DISPLAY_WIDTH (W),
        .DISPLAY_HEIGHT(H),
        .H_BITS        (HB),
        .V_BITS        (VB)
    ) dut (
        .clk_in           (clk),
        .rst_in           (rst_n),
        .start_in         (start_in),
        .cam_origin_in    (cam_origin_in),
        .cam_dir00_in     (cam_dir00_in),
        .cam_right_in     (cam_right_in),
        .cam_down_in      (cam_down_in),
        .fractal_sel_in   (fractal_sel_in),
        .ready_in         (ready_in),
        .valid_out        (valid_out),
        .ray_origin_out   (ray_origin_out),
        .ray_direction_out(ray_direction_out),
        .fractal_sel_out  (fractal_sel_out),
        .hcount_out       (hcount_out),
        .vcount_out       (vcount_out),
        .busy_out         (busy_out),
        .frame_done_out   (frame_done_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Independent reference: dir00 + h*right + v*down, wrapping at fp width.
    function automatic vec3 model_dir(input vec3 d0, input vec3 r, input vec3 dn, input int h, input int v);
        vec3 o;
        o.x = FP_W'(d0.x + fp'(h) * r.x + fp'(v) * dn.x);
        o.y = FP_W'(d0.y + fp'(h) * r.y + fp'(v) * dn.y);
        o.z = FP_W'(d0.z + fp'(h) * r.z + fp'(v) * dn.z);
        return o;
    endfunction

    // Monitor: a ray presented with ready high at negedge is accepted at the next posedge.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && frame_done_out) done_seen++;
        if (rst_n && valid_out && ready_in) begin
            if (exp_q.size() == 0) begin
                check("unexpected_transfer", 128'(1), 128'(0));
            end else begin
                e = exp_q.pop_front();
                check("hcount", 128'(hcount_out), 128'(e.h));
                check("vcount", 128'(vcount_out), 128'(e.v));
                check("direction", 128'(ray_direction_out), 128'(e.dir));
                check("origin", 128'(ray_origin_out), 128'(e.origin));
                check("fractal_sel", 128'(fractal_sel_out), 128'(e.sel));
            end
        end
    end

    vec3 f1_origin, f1_d0, f1_r, f1_dn;
    vec3 f2_origin, f2_d0, f2_r, f2_dn;

    // Frame 1 camera: hand-derived directions (0.25h, -0.25v, 1).
    task automatic setup_frame1();
        cam_origin_in  = f1_origin;
        cam_dir00_in   = f1_d0;
        cam_right_in   = f1_r;
        cam_down_in    = f1_dn;
        fractal_sel_in = 3'd2;
        for (int v = 0; v < int'(H); v++) begin
            for (int h = 0; h < int'(W); h++) begin
                exp_t e;
                e.h      = h;
                e.v      = v;
                e.dir    = make_vec3(fp_from_real(0.25 * h), fp_from_real(-0.25 * v), fp_from_real(1.0));
                e.origin = f1_origin;
                e.sel    = 3'd2;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start_in = 1'b1;
        @(posedge clk); #1 start_in = 1'b0;
    endtask

    task automatic run_frame1(input string tag);
        int n;
        int d;
        int done_at;
        setup_frame1();
        ready_in = 1'b1;
        pulse_start();
        check({tag, "_first_valid"}, 128'(valid_out), 128'(1));
        check({tag, "_first_h"}, 128'(hcount_out), 128'(0));
        check({tag, "_first_v"}, 128'(vcount_out), 128'(0));
        check({tag, "_busy"}, 128'(busy_out), 128'(1));
        n = 0;
        d = 0;
        done_at = -1;
        while (busy_out && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (frame_done_out) begin
                d++;
                done_at = n;
            end
        end
        if (n >= 200) check({tag, "_timeout"}, 128'(1), 128'(0));
        check({tag, "_frame_cycles"}, 128'(n + 1), 128'(W * H + 2));
        check({tag, "_done_pulses"}, 128'(d), 128'(1));
        check({tag, "_done_cycle"}, 128'(done_at), 128'(W * H));
        check({tag, "_idle_valid"}, 128'(valid_out), 128'(0));
        check({tag, "_queue_empty"}, 128'(exp_q.size()), 128'(0));
    endtask

    initial begin : stim
        int n;
        int d;
        int stalls;
        int done0;
        logic after_stall;

        f1_origin = make_vec3(fp_from_real(0.5), fp_from_real(-1.5), fp_from_real(-4.0));
        f1_d0     = make_vec3(fp_from_real(0.0), fp_from_real(0.0), fp_from_real(1.0));
        f1_r      = make_vec3(fp_from_real(0.25), fp_from_real(0.0), fp_from_real(0.0));
        f1_dn     = make_vec3(fp_from_real(0.0), fp_from_real(-0.25), fp_from_real(0.0));
        f2_origin = make_vec3(fp_from_real(1.0), fp_from_real(2.0), fp_from_real(3.0));
        f2_d0     = make_vec3(fp_from_real(-1.0), fp_from_real(0.5), fp_from_real(2.0));
        f2_r      = make_vec3(fp_from_real(0.5), fp_from_real(0.125), fp_from_real(0.0));
        f2_dn     = make_vec3(fp_from_real(0.0), fp_from_real(0.0), fp_from_real(-0.125));

        // Reset held with start asserted and live camera inputs.
        rst_n          = 1'b0;
        start_in       = 1'b1;
        ready_in       = 1'b1;
        cam_origin_in  = f2_origin;
        cam_dir00_in   = f2_d0;
        cam_right_in   = f2_r;
        cam_down_in    = f2_dn;
        fractal_sel_in = 3'd7;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 128'(valid_out), 128'(0));
        check("rst_origin", 128'(ray_origin_out), 128'(0));
        check("rst_dir", 128'(ray_direction_out), 128'(0));
        check("rst_sel", 128'(fractal_sel_out), 128'(0));
        check("rst_h", 128'(hcount_out), 128'(0));
        check("rst_v", 128'(vcount_out), 128'(0));
        check("rst_busy", 128'(busy_out), 128'(0));
        check("rst_done", 128'(frame_done_out), 128'(0));
        start_in = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;

        // Frame 1: full-rate raster with hand-computed directions.
        run_frame1("f1");

        // Frame 2: backpressure at (2,1) and ignored mid-frame camera/start changes.
        cam_origin_in  = f2_origin;
        cam_dir00_in   = f2_d0;
        cam_right_in   = f2_r;
        cam_down_in    = f2_dn;
        fractal_sel_in = 3'd5;
        for (int v = 0; v < int'(H); v++) begin
            for (int h = 0; h < int'(W); h++) begin
                exp_t e;
                e.h      = h;
                e.v      = v;
                e.dir    = model_dir(f2_d0, f2_r, f2_dn, h, v);
                e.origin = f2_origin;
                e.sel    = 3'd5;
                exp_q.push_back(e);
            end
        end
        ready_in = 1'b1;
        pulse_start();
        n = 0;
        d = 0;
        stalls = 0;
        after_stall = 1'b0;
        while (busy_out && n < 200) begin
            start_in = 1'b0;
            if (after_stall) begin
                check("f2_post_stall_h", 128'(hcount_out), 128'(3));
                check("f2_post_stall_v", 128'(vcount_out), 128'(1));
                after_stall = 1'b0;
            end
            if (valid_out && hcount_out == HB'(1) && vcount_out == VB'(0)) begin
                start_in       = 1'b1;
                cam_origin_in  = f1_origin;
                cam_dir00_in   = f1_d0;
                cam_right_in   = f1_r;
                cam_down_in    = f1_dn;
                fractal_sel_in = 3'd1;
            end
            if (valid_out && hcount_out == HB'(2) && vcount_out == VB'(1) && stalls < 5) begin
                if (stalls > 0) begin
                    check("f2_hold_h", 128'(hcount_out), 128'(2));
                    check("f2_hold_v", 128'(vcount_out), 128'(1));
                    check("f2_hold_dir", 128'(ray_direction_out), 128'(model_dir(f2_d0, f2_r, f2_dn, 2, 1)));
                    check("f2_hold_valid", 128'(valid_out), 128'(1));
                end
                ready_in = 1'b0;
                stalls++;
            end else begin
                if (!ready_in) after_stall = 1'b1;
                ready_in = 1'b1;
            end
            @(posedge clk); #1;
            n++;
            if (frame_done_out) d++;
        end
        start_in = 1'b0;
        ready_in = 1'b1;
        if (n >= 200) check("f2_timeout", 128'(1), 128'(0));
        check("f2_stalls", 128'(stalls), 128'(5));
        check("f2_done_pulses", 128'(d), 128'(1));
        check("f2_queue_empty", 128'(exp_q.size()), 128'(0));
        check("f2_busy_after", 128'(busy_out), 128'(0));

        // Frame 3: abort with reset at (1,1), no done pulse, then clean restart.
        setup_frame1();
        pulse_start();
        n = 0;
        while (!(hcount_out == HB'(1) && vcount_out == VB'(1)) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) check("f3_reach_timeout", 128'(1), 128'(0));
        done0 = done_seen;
        #1 rst_n = 1'b0;
        #1;
        check("abort_valid", 128'(valid_out), 128'(0));
        check("abort_h", 128'(hcount_out), 128'(0));
        check("abort_v", 128'(vcount_out), 128'(0));
        check("abort_dir", 128'(ray_direction_out), 128'(0));
        check("abort_busy", 128'(busy_out), 128'(0));
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("abort_no_done", 128'(done_seen - done0), 128'(0));
        check("abort_idle", 128'(busy_out), 128'(0));

        run_frame1("f4");

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
